kamikaze_instr_align: RTL and testbench
=======================================

Name: kamikaze_instr_align

Overview:
Instruction aligner between the instruction-memory word stream and decode. Accepts 32-bit aligned fetch words and buffers them as halfwords. Emits one whole RV32IC instruction per handshake, with its PC and a compressed flag; 16-bit instructions and 32-bit instructions that straddle a word boundary are both handled. Also owns the word fetch address and accepts PC redirects from execute.

Parameters:
RESET_PC, 32'h0000_0000, first PC after reset; bit0 must be 0.
QDEPTH_HW, 4, halfword queue capacity; fixed at 4 for this revision.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-low
fetch_addr_o  out  32  word address presented to instruction memory; bits[1:0] always 00
word_i  in  32  fetch word for the previous fetch_addr_o; little-endian halfwords
word_valid_i  in  1  word_i carries data
word_ready_o  out  1  aligner accepts word_i this cycle
redirect_i  in  1  flush and restart at redirect_pc_i
redirect_pc_i  in  32  new PC; bit0 ignored
instr_o  out  32  aligned instruction; compressed ones zero-extended in [31:16]
instr_pc_o  out  32  PC of instr_o
instr_compressed_o  out  1  1 when instr_o[1:0] != 2'b11
instr_valid_o  out  1  instr_o is complete
instr_ready_i  in  1  decode consumes instr_o

Behaviour:
- State:
  - 64-bit halfword queue, head at [15:0].
  - count in 0..4.
  - pc register.
  - fetch_addr register.
  - drop_half flag.
- Reset (rst_i low, async):
  - count=0, pc=RESET_PC, fetch_addr_o={RESET_PC[31:2],2'b00}.
  - drop_half=RESET_PC[1], instr_valid_o=0, instr_pc_o=RESET_PC.
- word_ready_o = (count <= 2) && !redirect_i, computed from current count only (no pop forwarding). It reads 1 out of reset.
- Push: word_valid_i && word_ready_o at posedge.
  - The word is appended behind existing halfwords; count += 2.
  - fetch_addr_o += 4, taking effect in the next cycle.
  - If drop_half=1, only word_i[31:16] is appended, count += 1, and drop_half clears.
- Head classification:
  - head[1:0] != 2'b11 → compressed; needs count>=1.
  - Otherwise → 32-bit; needs count>=2.
- instr_valid_o = head complete per the rule above, and not redirect_i.
- instr_o / instr_pc_o / instr_compressed_o are driven from queue head and pc. They are valid in the cycle after the push edge, so word-to-instruction latency is 1 edge.
- Pop: instr_valid_o && instr_ready_i.
  - Shift out 1 or 2 halfwords; count -= 1 or 2.
  - pc += 2 or 4 (32-bit wrap).
- Push and pop on the same edge: the pop shift is applied first, then the append. The result never exceeds 4 because push requires count<=2.
- instr_o is stable while instr_valid_o=1 and instr_ready_i=0.
- Redirect has highest priority and is a one-cycle action:
  - count=0, pc={redirect_pc_i[31:1],1'b0}, fetch_addr_o={redirect_pc_i[31:2],2'b00}, drop_half=redirect_pc_i[1].
  - Any concurrent push or pop is discarded.
  - instr_valid_o and word_ready_o are 0 in that cycle.
- Back-to-back redirects: the last one wins.
- A redirect while drop_half is already set simply reloads drop_half.
- Empty queue with word_valid_i=0: instr_valid_o=0, and pc and fetch_addr_o hold.
- A 32-bit head with count==1 waits for the next word. It is never emitted partially.
- Memory latency contract: word_i arriving while word_ready_o=1 belongs to the fetch_addr_o of the previous cycle. The memory holds its output while word_ready_o=0.

Decomposition:
- Shared package kamikaze_pkg:
  - RVC_OPC_FULL = 2'b11
  - HALFWORD_W = 16
  - RESET_PC default
  - function is_compressed(logic [1:0])
- Sub-module kamikaze_halfword_queue owns the 4x16 queue with push1/push2/pop1/pop2 and count.
- The aligner top holds pc, fetch_addr, drop_half, redirect and handshake logic.

Test Plan:
1. Reset, RESET_PC=0; words 0x00000013 at 0x0 and 0x4 with instr_ready_i=1 → instr 0x00000013 at pc 0x0 then 0x4, compressed=0; fetch_addr_o walks 0x0, 0x4, 0x8.
2. Word 0x45014505 → pc 0x0 instr 0x00004505 c=1, then pc 0x2 instr 0x00004501 c=1; fetch_addr_o 0x4.
3. Straddle: words 0x00934501, 0x45050010 → pc 0x0 0x00004501 c=1; pc 0x2 0x00100093 c=0, emitted only after the second word; pc 0x6 0x00004505 c=1.
4. Backpressure: instr_ready_i=0, words 0x00000013 and 0x00100093 pushed → count=4, word_ready_o=0, fetch_addr_o holds 0x8; release → both instructions emitted in order, none lost or duplicated.
5. Redirect to 0x102 mid-stream → same cycle instr_valid_o=0; next fetch_addr_o=0x100; word 0x4505ABCD → instr 0x00004505 at pc 0x102, c=1; the 0xABCD half is never emitted.
6. rst_i pulled low mid-stream with count=3 → asynchronously instr_valid_o=0 and fetch_addr_o=RESET_PC; after release the first instruction is at RESET_PC.

Source files
------------

// File: rtl/kamikaze_pkg.sv
// Shared constants and helpers for the kamikaze instruction aligner.
// Halfword geometry, RVC opcode marker and the default reset PC live here.
package kamikaze_pkg;

    localparam logic [1:0]  RVC_OPC_FULL     = 2'b11;
    localparam int          HALFWORD_W       = 16;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // A halfword whose low two bits are not 11 starts a 16-bit instruction.
    function automatic logic is_compressed(input logic [1:0] opc);
        return opc != RVC_OPC_FULL;
    endfunction

endpackage

// File: rtl/kamikaze_halfword_queue.sv
// Small halfword FIFO: shift out 1 or 2 from the head, append 1 or 2 behind.
// A pop and a push on the same edge apply the shift first, then the append.
module kamikaze_halfword_queue
    import kamikaze_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    pop_i,
    input  logic                    pop_two_i,
    input  logic                    push_i,
    input  logic                    push_one_i,
    input  logic [2*HALFWORD_W-1:0] push_word_i,
    output logic [2*HALFWORD_W-1:0] head_o,
    output logic [2:0]              count_o
);

    localparam int QW = DEPTH * HALFWORD_W;

    logic [QW-1:0] data_q, data_d, shifted;
    logic [2:0]    count_q, count_d, base;
    logic [1:0]    pop_n;

    always_comb begin
        pop_n = 2'd0;
        if (pop_i) begin
            pop_n = pop_two_i ? 2'd2 : 2'd1;
        end
        shifted = data_q >> (HALFWORD_W * int'(pop_n));
        base    = count_q - {1'b0, pop_n};
        data_d  = shifted;
        count_d = base;
        if (push_i) begin
            // With push_one_i only the upper halfword of the word is kept.
            for (int i = 0; i < DEPTH; i++) begin
                if (3'(i) == base) begin
                    data_d[i*HALFWORD_W +: HALFWORD_W] =
                        push_one_i ? push_word_i[2*HALFWORD_W-1:HALFWORD_W]
                                   : push_word_i[HALFWORD_W-1:0];
                end else if (!push_one_i && (3'(i) == 3'(base + 3'd1))) begin
                    data_d[i*HALFWORD_W +: HALFWORD_W] = push_word_i[2*HALFWORD_W-1:HALFWORD_W];
                end
            end
            count_d = base + (push_one_i ? 3'd1 : 3'd2);
        end
        if (flush_i) begin
            data_d  = '0;
            count_d = 3'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_q  <= '0;
            count_q <= 3'd0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign head_o  = data_q[2*HALFWORD_W-1:0];
    assign count_o = count_q;

endmodule

// File: rtl/kamikaze_instr_align.sv
// RV32IC instruction aligner: buffers fetch words as halfwords and emits whole
// instructions with their PC; owns the word fetch address and PC redirects.
module kamikaze_instr_align
    import kamikaze_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          QDEPTH_HW = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] fetch_addr_o,
    input  logic [31:0] word_i,
    input  logic        word_valid_i,
    output logic        word_ready_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_compressed_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic        drop_half_q, drop_half_d;
    logic [31:0] q_head;
    logic [2:0]  q_count;
    logic        head_compressed, head_complete, push, pop;

    assign head_compressed = is_compressed(q_head[1:0]);
    assign head_complete   = head_compressed ? (q_count >= 3'd1) : (q_count >= 3'd2);

    // Both ports transfer on a rising edge where valid and ready are high;
    // ready/valid never look at the opposite side's ready, and redirect kills both.
    assign word_ready_o  = (q_count <= 3'd2) && !redirect_i;
    assign instr_valid_o = head_complete && !redirect_i;
    assign push          = word_valid_i && word_ready_o;
    assign pop           = instr_valid_o && instr_ready_i;

    assign instr_o            = head_compressed ? {16'h0000, q_head[15:0]} : q_head;
    assign instr_compressed_o = head_compressed;
    assign instr_pc_o         = pc_q;
    assign fetch_addr_o       = fetch_addr_q;

    always_comb begin
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        drop_half_d  = drop_half_q;
        if (redirect_i) begin
            pc_d         = redirect_pc_i & ~32'h1;
            fetch_addr_d = redirect_pc_i & ~32'h3;
            drop_half_d  = redirect_pc_i[1];
        end else begin
            if (pop) begin
                pc_d = pc_q + (head_compressed ? 32'd2 : 32'd4);
            end
            if (push) begin
                fetch_addr_d = fetch_addr_q + 32'd4;
                drop_half_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC & ~32'h3;
            drop_half_q  <= RESET_PC[1];
        end else begin
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            drop_half_q  <= drop_half_d;
        end
    end

    // A pending drop_half discards the low halfword of the first word after a redirect.
    kamikaze_halfword_queue #(
        .DEPTH(QDEPTH_HW)
    ) u_queue (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (redirect_i),
        .pop_i      (pop),
        .pop_two_i  (!head_compressed),
        .push_i     (push),
        .push_one_i (drop_half_q),
        .push_word_i(word_i),
        .head_o     (q_head),
        .count_o    (q_count)
    );

endmodule

// File: tb/tb_kamikaze_instr_align.sv
// Bench for kamikaze_instr_align: address-level reference model over a word memory,
// directed scenarios pinned by literal expectations, then a randomized run.
module tb_kamikaze_instr_align;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] fetch_addr_o;
  logic [31:0] word_i = 32'h0;
  logic        word_valid_i = 1'b0;
  logic        word_ready_o;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_compressed_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;

  always #5 clk_i = ~clk_i;

  kamikaze_instr_align #(
    .RESET_PC (RESET_PC),
    .QDEPTH_HW(4)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .fetch_addr_o      (fetch_addr_o),
    .word_i            (word_i),
    .word_valid_i      (word_valid_i),
    .word_ready_o      (word_ready_o),
    .redirect_i        (redirect_i),
    .redirect_pc_i     (redirect_pc_i),
    .instr_o           (instr_o),
    .instr_pc_o        (instr_pc_o),
    .instr_compressed_o(instr_compressed_o),
    .instr_valid_o     (instr_valid_o),
    .instr_ready_i     (instr_ready_i)
  );

  logic [31:0] mem [0:255];
  logic [64:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  int mem_valid_pct = 100;

  function automatic logic [15:0] mem16(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory: answers one cycle later for the previous cycle's fetch_addr_o,
  // holds while not accepted, drops its answer on redirect or once consumed.
  logic        c_push, c_red, c_ready;
  logic [31:0] c_fa;
  always @(negedge clk_i) begin
    c_push  = word_valid_i && word_ready_o;
    c_red   = redirect_i;
    c_ready = word_ready_o;
    c_fa    = fetch_addr_o;
  end
  always @(posedge clk_i) begin
    #1;
    if (!rst_i || c_red || c_push) begin
      word_valid_i = 1'b0;
    end else if (!(word_valid_i && !c_ready)) begin
      word_i       = mem[c_fa[9:2]];
      word_valid_i = ($urandom_range(99) < mem_valid_pct);
    end
  end

  // Reference model: buffered halfwords = (fetch address - pc) / 2.
  logic [31:0] m_pc, m_fa, prev_instr;
  logic        prev_stall;
  always @(negedge clk_i) begin : compare
    int          cnt;
    logic [15:0] hw0;
    logic        comp, exp_valid, exp_wr;
    logic [31:0] exp_instr;
    logic [64:0] e;
    if (!rst_i) begin
      m_pc       = RESET_PC & ~32'h1;
      m_fa       = RESET_PC & ~32'h3;
      prev_stall = 1'b0;
    end else begin
      cnt = $signed(m_fa - m_pc);
      cnt = cnt >>> 1;
      if (cnt < 0) cnt = 0;
      hw0       = mem16(m_pc);
      comp      = (hw0[1:0] != 2'b11);
      exp_instr = comp ? {16'h0000, hw0} : {mem16(m_pc + 32'd2), hw0};
      exp_valid = !redirect_i && (comp ? (cnt >= 1) : (cnt >= 2));
      exp_wr    = !redirect_i && (cnt <= 2);
      check("fetch_addr", fetch_addr_o, m_fa);
      check("word_ready", 32'(word_ready_o), 32'(exp_wr));
      check("instr_valid", 32'(instr_valid_o), 32'(exp_valid));
      if (exp_valid && instr_valid_o) begin
        check("instr", instr_o, exp_instr);
        check("instr_pc", instr_pc_o, m_pc);
        check("compressed", 32'(instr_compressed_o), 32'(comp));
      end
      if (prev_stall && !redirect_i) check("stall_hold", instr_o, prev_instr);
      prev_stall = instr_valid_o && !instr_ready_i;
      prev_instr = instr_o;
      if (exp_valid && instr_valid_o && instr_ready_i) begin
        hs_cnt++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("lit_pc", instr_pc_o, e[64:33]);
          check("lit_instr", instr_o, e[32:1]);
          check("lit_c", 32'(instr_compressed_o), 32'(e[0]));
        end
        m_pc = m_pc + (comp ? 32'd2 : 32'd4);
      end
      if (word_valid_i && exp_wr) m_fa = m_fa + 32'd4;
      if (redirect_i) begin
        m_pc = redirect_pc_i & ~32'h1;
        m_fa = redirect_pc_i & ~32'h3;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic do_reset();
    rst_i         = 1'b0;
    redirect_i    = 1'b0;
    instr_ready_i = 1'b0;
    tick(3);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick(1);
  endtask

  task automatic drain(input string name, input int bound);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain actual_left=%0d required_left=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int hs_start;
    mem_valid_pct = 100;

    // Reset state and two aligned 32-bit instructions.
    clear_mem();
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0000_0013;
    rst_i = 1'b0;
    #2;
    check("reset_valid", 32'(instr_valid_o), 32'h0);
    check("reset_fetch", fetch_addr_o, RESET_PC);
    check("reset_pc", instr_pc_o, RESET_PC);
    check("reset_wready", 32'(word_ready_o), 32'h1);
    do_reset();
    exp_q.push_back({32'h0, 32'h0000_0013, 1'b0});
    exp_q.push_back({32'h4, 32'h0000_0013, 1'b0});
    instr_ready_i = 1'b1;
    drain("t1", 40);
    check("t1_fetch", fetch_addr_o, 32'h8);

    // Two compressed instructions in one word.
    clear_mem();
    mem[0] = 32'h4501_4505;
    do_reset();
    exp_q.push_back({32'h0, 32'h0000_4505, 1'b1});
    exp_q.push_back({32'h2, 32'h0000_4501, 1'b1});
    instr_ready_i = 1'b1;
    drain("t2", 40);

    // 32-bit instruction straddling a word boundary.
    clear_mem();
    mem[0] = 32'h0093_4501;
    mem[1] = 32'h4505_0010;
    do_reset();
    exp_q.push_back({32'h0, 32'h0000_4501, 1'b1});
    exp_q.push_back({32'h2, 32'h0010_0093, 1'b0});
    exp_q.push_back({32'h6, 32'h0000_4505, 1'b1});
    instr_ready_i = 1'b1;
    drain("t3", 40);

    // Backpressure fills the queue and stalls fetch.
    clear_mem();
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    do_reset();
    tick(10);
    check("t4_wready", 32'(word_ready_o), 32'h0);
    check("t4_fetch", fetch_addr_o, 32'h8);
    exp_q.push_back({32'h0, 32'h0000_0013, 1'b0});
    exp_q.push_back({32'h4, 32'h0010_0093, 1'b0});
    instr_ready_i = 1'b1;
    drain("t4", 40);

    // Redirect to a halfword-aligned target mid-stream.
    clear_mem();
    mem[0]  = 32'h0000_0013;
    mem[1]  = 32'h0000_0013;
    mem[64] = 32'h4505_ABCD;
    do_reset();
    instr_ready_i = 1'b1;
    tick(4);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0102;
    exp_q.push_back({32'h102, 32'h0000_4505, 1'b1});
    tick(1);
    redirect_i = 1'b0;
    check("t5_fetch", fetch_addr_o, 32'h100);
    drain("t5", 40);

    // Asynchronous reset with three halfwords buffered.
    clear_mem();
    mem[0] = 32'h4501_4505;
    mem[1] = 32'h0000_0013;
    do_reset();
    tick(8);
    instr_ready_i = 1'b1;
    tick(1);
    instr_ready_i = 1'b0;
    check("t6_fetch_pre", fetch_addr_o, 32'h8);
    rst_i = 1'b0;
    #1;
    check("t6_async_valid", 32'(instr_valid_o), 32'h0);
    check("t6_async_fetch", fetch_addr_o, RESET_PC);
    tick(2);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick(1);
    exp_q.push_back({RESET_PC, 32'h0000_4505, 1'b1});
    instr_ready_i = 1'b1;
    drain("t6", 40);

    // Randomized stream with random redirects (bit0 may be set) and backpressure.
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem_valid_pct = 75;
    do_reset();
    hs_start = hs_cnt;
    for (int i = 0; i < 3000; i++) begin
      instr_ready_i = ($urandom_range(99) < 70);
      redirect_i    = ($urandom_range(99) < 3);
      redirect_pc_i = 32'($urandom_range(1023));
      tick(1);
    end
    redirect_i = 1'b0;
    tick(2);
    checks++;
    if (hs_cnt - hs_start < 100) begin
      failures++;
      $display("FAIL random_progress actual=%0d required>=100", hs_cnt - hs_start);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
